// File: rtl/transpose_buffer_pkg.sv
// transpose_pkg
// Shared definitions for the ping-pong transpose buffer: default sample
// width and bank depth, largest supported block edge, the bank and FSM
// state encodings, and the block-size decode helpers.
// No ports (package).
package transpose_pkg;

  localparam int DW    = 16;
  localparam int DEPTH = 64;
  localparam int MAX_N = 8;

  localparam logic [1:0] N_4X4 = 2'b00;
  localparam logic [1:0] N_8X8 = 2'b01;

  typedef enum logic [1:0] {
    B_EMPTY,
    B_FILLING,
    B_FULL,
    B_DRAINING
  } bank_state_t;

  typedef enum logic {
    W_IDLE,
    W_FILL
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_DRAIN
  } r_state_t;

  // Block edge length for an N code; 0 marks a reserved code.
  function automatic logic [3:0] n_to_size(input logic [1:0] n);
    case (n)
      N_4X4:   return 4'd4;
      N_8X8:   return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  // Index of the final sample of a block (N*N-1).
  function automatic logic [5:0] last_index(input logic is8);
    return is8 ? 6'(MAX_N * MAX_N - 1) : 6'((MAX_N / 2) * (MAX_N / 2) - 1);
  endfunction

endpackage

// File: rtl/transpose_buffer_if.sv
// transpose_buffer_if
// Groups the sample/handshake signals of the transpose buffer.
//   master: producer/consumer side (drives N, write, data_in, read)
//   slave : the buffer itself (drives data_out, out_valid, ready_in,
//           block_avail, wr_count, rd_count, err)
interface transpose_buffer_if #(
  parameter int DW = transpose_pkg::DW
);
  logic [1:0]    N;
  logic          write;
  logic [DW-1:0] data_in;
  logic          read;
  logic [DW-1:0] data_out;
  logic          out_valid;
  logic          ready_in;
  logic          block_avail;
  logic [5:0]    wr_count;
  logic [5:0]    rd_count;
  logic          err;

  modport master (
    output N, write, data_in, read,
    input  data_out, out_valid, ready_in, block_avail, wr_count, rd_count, err
  );

  modport slave (
    input  N, write, data_in, read,
    output data_out, out_valid, ready_in, block_avail, wr_count, rd_count, err
  );
endinterface

// File: rtl/transpose_buffer_bank.sv
// transpose_bank
// One DEPTH x DW sample store with synchronous write and a registered read.
//   clk, reset : clock, async active-high reset (clears the read register only)
//   we/waddr/wdata : write port
//   re/raddr       : read request; rdata updates on the following edge
module transpose_bank #(
  parameter int DW    = 16,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Storage is deliberately not reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/transpose_buffer.sv
// transpose_buffer
// Ping-pong transpose buffer between two DCT passes. Row-major samples are
// written into one bank while the other bank is read out column-major.
//   clk, reset : clock, async active-high reset
//   bus        : transpose_buffer_if.slave (N, write, data_in, read in;
//                data_out, out_valid, ready_in, block_avail, wr_count,
//                rd_count, err out)
module transpose_buffer #(
  parameter int DW    = transpose_pkg::DW,
  parameter int DEPTH = transpose_pkg::DEPTH
) (
  input logic               clk,
  input logic               reset,
  transpose_buffer_if.slave bus
);
  import transpose_pkg::*;

  localparam int AW = $clog2(DEPTH);

  bank_state_t   bank_state    [2];
  bank_state_t   bank_state_nx [2];
  w_state_t      w_state, w_state_nx;
  r_state_t      r_state, r_state_nx;
  logic          fill_ptr, fill_ptr_nx;
  logic          drain_ptr, drain_ptr_nx;
  logic [1:0]    bank_is8, bank_is8_nx;
  logic [5:0]    wr_count, wr_count_nx;
  logic [5:0]    rd_count, rd_count_nx;
  logic          err, err_nx;
  logic          out_valid, out_valid_nx;
  logic          rd_sel, rd_sel_nx;
  logic          ready, avail;
  logic [1:0]    we, re;
  logic [5:0]    rd_index;
  logic [DW-1:0] rdata_a, rdata_b;

  // The fill bank can take data unless both banks hold finished blocks;
  // the drain bank can be read once it holds a finished block.
  assign ready = (bank_state[fill_ptr] == B_EMPTY) || (bank_state[fill_ptr] == B_FILLING);
  assign avail = (bank_state[drain_ptr] == B_FULL) || (bank_state[drain_ptr] == B_DRAINING);

  // Column-major address: (rd_count % N)*N + rd_count / N, using the
  // drain bank's latched size.
  always_comb begin
    rd_index = '0;
    if (bank_is8[drain_ptr]) rd_index = {rd_count[2:0], rd_count[5:3]};
    else                     rd_index = {2'b00, rd_count[1:0], rd_count[3:2]};
  end

  // Write and read sides always touch different banks (fill bank is
  // EMPTY/FILLING, drain bank is FULL/DRAINING), so both may update
  // bank state in the same cycle.
  always_comb begin
    bank_state_nx = bank_state;
    w_state_nx    = w_state;
    r_state_nx    = r_state;
    fill_ptr_nx   = fill_ptr;
    drain_ptr_nx  = drain_ptr;
    bank_is8_nx   = bank_is8;
    wr_count_nx   = wr_count;
    rd_count_nx   = rd_count;
    err_nx        = err;
    out_valid_nx  = 1'b0;
    rd_sel_nx     = rd_sel;
    we            = 2'b00;
    re            = 2'b00;

    if (bus.write) begin
      if (!ready) begin
        err_nx = 1'b1;
      end else if (w_state == W_IDLE) begin
        // First sample of a block latches N; a reserved code drops it.
        if (n_to_size(bus.N) == 4'd0) begin
          err_nx = 1'b1;
        end else begin
          bank_is8_nx[fill_ptr]   = (n_to_size(bus.N) == 4'(MAX_N));
          bank_state_nx[fill_ptr] = B_FILLING;
          w_state_nx              = W_FILL;
          wr_count_nx             = 6'd1;
          we[fill_ptr]            = 1'b1;
        end
      end else begin
        we[fill_ptr] = 1'b1;
        if (wr_count == last_index(bank_is8[fill_ptr])) begin
          wr_count_nx             = '0;
          bank_state_nx[fill_ptr] = B_FULL;
          fill_ptr_nx             = ~fill_ptr;
          w_state_nx              = W_IDLE;
        end else begin
          wr_count_nx = wr_count + 6'd1;
        end
      end
    end

    if (bus.read && avail) begin
      re[drain_ptr] = 1'b1;
      out_valid_nx  = 1'b1;
      rd_sel_nx     = drain_ptr;
      if (r_state == R_IDLE) begin
        bank_state_nx[drain_ptr] = B_DRAINING;
        r_state_nx               = R_DRAIN;
      end
      if (rd_count == last_index(bank_is8[drain_ptr])) begin
        rd_count_nx              = '0;
        bank_state_nx[drain_ptr] = B_EMPTY;
        drain_ptr_nx             = ~drain_ptr;
        r_state_nx               = R_IDLE;
      end else begin
        rd_count_nx = rd_count + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_state[0] <= B_EMPTY;
      bank_state[1] <= B_EMPTY;
      w_state       <= W_IDLE;
      r_state       <= R_IDLE;
      fill_ptr      <= 1'b0;
      drain_ptr     <= 1'b0;
      bank_is8      <= '0;
      wr_count      <= '0;
      rd_count      <= '0;
      err           <= 1'b0;
      out_valid     <= 1'b0;
      rd_sel        <= 1'b0;
    end else begin
      bank_state    <= bank_state_nx;
      w_state       <= w_state_nx;
      r_state       <= r_state_nx;
      fill_ptr      <= fill_ptr_nx;
      drain_ptr     <= drain_ptr_nx;
      bank_is8      <= bank_is8_nx;
      wr_count      <= wr_count_nx;
      rd_count      <= rd_count_nx;
      err           <= err_nx;
      out_valid     <= out_valid_nx;
      rd_sel        <= rd_sel_nx;
    end
  end

  transpose_bank #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_bank_a (
    .clk   (clk),
    .reset (reset),
    .we    (we[0]),
    .waddr (AW'(wr_count)),
    .wdata (bus.data_in),
    .re    (re[0]),
    .raddr (AW'(rd_index)),
    .rdata (rdata_a)
  );

  transpose_bank #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_bank_b (
    .clk   (clk),
    .reset (reset),
    .we    (we[1]),
    .waddr (AW'(wr_count)),
    .wdata (bus.data_in),
    .re    (re[1]),
    .raddr (AW'(rd_index)),
    .rdata (rdata_b)
  );

  // Both bank read registers reset to 0 and rd_sel resets to bank A,
  // so data_out is 0 out of reset.
  assign bus.data_out    = rd_sel ? rdata_b : rdata_a;
  assign bus.out_valid   = out_valid;
  assign bus.ready_in    = ready;
  assign bus.block_avail = avail;
  assign bus.wr_count    = wr_count;
  assign bus.rd_count    = rd_count;
  assign bus.err         = err;

endmodule

// File: doc/transpose_buffer.md
TRANSPOSE_BUFFER -- requirements
Module: transpose_buffer

Interface
REQ-001 SHALL have parameter DW, default 16, sample width in bits (signed two's complement).
REQ-002 SHALL have parameter DEPTH, default 64, entries per bank (max block 8x8).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high; clears all state.
REQ-005 Port: N  input  2  block size: 2'b00 = 4x4, 2'b01 = 8x8, 2'b10/2'b11 reserved.
REQ-006 Port: write  input  1  strobe, one row-major sample from the first-pass DCT.
REQ-007 Port: data_in  input  DW  sample accompanying write.
REQ-008 Port: read  input  1  request for the next column-major sample for the second pass.
REQ-009 Port: data_out  output  DW  registered transposed sample.
REQ-010 Port: out_valid  output  1  data_out holds a sample returned for a read accepted last cycle.
REQ-011 Port: ready_in  output  1  a bank is free or filling, so write will be accepted.
REQ-012 Port: block_avail  output  1  a full bank is ready or draining, so read will be accepted.
REQ-013 Port: wr_count  output  6  samples written into the current fill bank.
REQ-014 Port: rd_count  output  6  samples read from the current drain bank.
REQ-015 Port: err  output  1  sticky error flag.

Function
REQ-016 Two banks, A and B, ping-pong; each bank is EMPTY, FILLING, FULL or DRAINING.
REQ-017 Write side FSM is W_IDLE -> W_FILL on the first accepted write; W_FILL -> W_IDLE after sample N*N-1, bank to FULL, fill pointer toggles.
REQ-018 N SHALL be latched per bank on that bank's first write; N changes mid-block are ignored.
REQ-019 Write address = wr_count (row-major; row = wr_count / N, col = wr_count % N).
REQ-020 Read side FSM is R_IDLE -> R_DRAIN on the first accepted read; R_DRAIN -> R_IDLE after sample N*N-1, bank to EMPTY, drain pointer toggles.
REQ-021 Read address = (rd_count % N)*N + (rd_count / N) (column-major, using the drain bank's latched N).
REQ-022 Read latency is 1 cycle: read accepted at edge t -> data_out/out_valid at edge t+1; out_valid low otherwise.
REQ-023 Write while ready_in=0 (both banks FULL/DRAINING): sample dropped, no counter change, err set.
REQ-024 Read while block_avail=0: ignored, out_valid stays 0, err not set.
REQ-025 Write with N reserved on the first sample of a block: dropped, bank stays EMPTY, err set.
REQ-026 Simultaneous last write into bank X and read: read is served from the other bank if it is FULL/DRAINING; otherwise it is ignored. Bank X becomes readable the next cycle.
REQ-027 Simultaneous last read of bank X and write when the other bank is FULL: bank X is writable the next cycle, not the same cycle.
REQ-028 wr_count and rd_count wrap to 0 at block end; they never exceed N*N-1.

Reset
REQ-029 On reset, all outputs SHALL go to 0 except ready_in=1: data_out=0, out_valid=0, block_avail=0, wr_count=0, rd_count=0, err=0.
REQ-030 Reset SHALL set both banks to EMPTY, both pointers to bank A and both FSMs to IDLE; RAM contents are not cleared.
REQ-031 Reset asserted mid-block SHALL discard partial and full blocks; no out_valid after reset.

Structure
REQ-032 Shared package transpose_pkg SHALL hold DW, DEPTH, MAX_N=8, the bank-state and FSM-state enums, and the N-to-size decode function.
REQ-033 One sub-module transpose_bank (DEPTH x DW, synchronous write, registered read) SHALL be instantiated twice.

Verification
REQ-034 N=00; write 0..15; then 16 reads -> data_out sequence 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15, each 1 cycle after its read.
REQ-035 N=01; write 0..63, then immediately write 100..163 while reading -> first drain gives 0,8,16,...,56,1,9,...,63; second block is then readable with no stall.
REQ-036 N=00; fill both banks (32 writes); a 33rd write -> dropped, err=1, wr_count unchanged, ready_in=0.
REQ-037 Read with no full bank -> out_valid=0, err=0, rd_count=0.
REQ-038 N=01; 20 writes, reset pulse, then 64 writes -> first read returns the new sample 0, block_avail=1 only after write 64.
REQ-039 Switch N from 00 to 01 after 5 writes -> block still completes at 16 samples with 4x4 transpose order.
